// File: rtl/eeprom_access_arbiter.sv
// Round-robin arbiter sharing one I2C EEPROM read/write engine between two clients.
// Issues the strobe, waits for ack under a watchdog, then returns done/err/rdata.
module eeprom_access_arbiter #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 8,
  parameter int ISSUE_CYC = 2,
  parameter int TIMEOUT   = 4096,
  parameter int TO_W      = 13
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_done0,
  output logic              o_done1,
  output logic              o_err0,
  output logic              o_err1,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_eng_wr,
  output logic              o_eng_rd,
  output logic [ADDR_W-1:0] o_eng_addr,
  output logic [DATA_W-1:0] o_eng_wdata,
  output logic              o_eng_data_oe,
  input  logic [DATA_W-1:0] i_eng_rdata,
  input  logic              i_eng_ack,
  output logic              o_busy
);

  // state    | meaning
  // IDLE     | arbitrate; capture winner's request, pulse its gnt
  // ISSUE    | hold eng_wr/eng_rd for ISSUE_CYC cycles
  // WAIT_ACK | strobes low, bus held; watchdog counts until ack or expiry
  // RESP     | pulse done/err of the owner, flip rr pointer, drop oe
  // GAP      | one quiet cycle so the engine sees WR/RD low before next request
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_RESP,
    S_GAP
  } state_t;

  localparam int IC_W = (ISSUE_CYC > 1) ? $clog2(ISSUE_CYC) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner;
  logic              r_rr;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;
  logic [IC_W-1:0]   r_issue_cnt;
  logic [TO_W-1:0]   r_wd;

  logic              w_sel_valid;
  logic              w_sel;
  logic              w_wd_expired;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b0;
      r_rr        <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_issue_cnt <= '0;
      r_wd        <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_sel_valid) begin
            r_owner     <= w_sel;
            r_we        <= w_sel ? i_we1 : i_we0;
            r_addr      <= w_sel ? i_addr1 : i_addr0;
            r_wdata     <= w_sel ? i_wdata1 : i_wdata0;
            r_issue_cnt <= IC_W'(ISSUE_CYC - 1);
          end
        end
        S_ISSUE: begin
          if (r_issue_cnt != '0) begin
            r_issue_cnt <= r_issue_cnt - 1'b1;
          end
        end
        S_WAIT_ACK: begin
          r_wd <= r_wd + 1'b1;
          // ack has priority over a watchdog expiry in the same cycle
          if (i_eng_ack) begin
            r_err <= 1'b0;
            if (!r_we) begin
              r_rdata <= i_eng_rdata;
            end
          end else if (w_wd_expired) begin
            r_err <= 1'b1;
          end
        end
        S_RESP: begin
          r_rr <= ~r_owner;
          r_wd <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_valid  = 1'b0;
    w_sel        = r_rr;
    w_wd_expired = (r_wd == TO_W'(TIMEOUT - 1));
    case (r_state)
      S_IDLE: begin
        if (i_req0 && i_req1) begin
          w_sel_valid = 1'b1;
          w_sel       = r_rr;
        end else if (i_req0) begin
          w_sel_valid = 1'b1;
          w_sel       = 1'b0;
        end else if (i_req1) begin
          w_sel_valid = 1'b1;
          w_sel       = 1'b1;
        end
        if (w_sel_valid) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_issue_cnt == '0) begin
          w_state_nxt = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (i_eng_ack || w_wd_expired) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: w_state_nxt = S_GAP;
      S_GAP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_gnt0        = w_sel_valid && !w_sel && !RESET;
    o_gnt1        = w_sel_valid && w_sel && !RESET;
    o_done0       = (r_state == S_RESP) && !r_owner;
    o_done1       = (r_state == S_RESP) && r_owner;
    o_err0        = o_done0 && r_err;
    o_err1        = o_done1 && r_err;
    o_rdata       = r_rdata;
    o_eng_wr      = (r_state == S_ISSUE) && r_we;
    o_eng_rd      = (r_state == S_ISSUE) && !r_we;
    o_eng_addr    = r_addr;
    o_eng_wdata   = r_wdata;
    o_eng_data_oe = ((r_state == S_ISSUE) || (r_state == S_WAIT_ACK)) && r_we;
    o_busy        = (r_state != S_IDLE);
  end

endmodule
